// File: rtl/irq_pending_arbiter.sv
// Sticky request capture with masked highest-index arbitration and a registered valid/ready offer.
// Optional IRQ_EDGE_DETECT_EN: events are rising edges of req_in instead of levels.
module irq_pending_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask_in,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending_o,
  output logic [N-1:0]     ovf_o
);

  // Handshake: an offer (out_valid, out_idx) is held unchanged until a clock edge
  // sees out_valid && out_ready; that edge is the transfer and clears the offered bit.
  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_next;
  logic [N-1:0]     pending, ovf, events, clr_vec, eligible;
  logic             valid_next;
  logic [IDX_W-1:0] idx_next, top_idx;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] req_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_prev <= '0;
    else        req_prev <= req_in;
  end

  assign events = req_in & ~req_prev;
`else
  assign events = req_in;
`endif

  assign eligible  = pending & mask_in;
  assign pending_o = pending;
  assign ovf_o     = ovf;

  always_comb begin
    clr_vec = '0;
    if (out_valid && out_ready) clr_vec[out_idx] = 1'b1;
  end

  // Ascending scan so the highest set index is the one that sticks.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) top_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    valid_next = out_valid;
    idx_next   = out_idx;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (eligible != '0) begin
          state_next = OFFER;
          valid_next = 1'b1;
          idx_next   = top_idx;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      state     <= state_next;
      out_valid <= valid_next;
      out_idx   <= idx_next;
    end
  end

  // A new event on the bit being granted re-arms it rather than counting as lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | events;
      ovf     <= (clear_ovf ? '0 : ovf) | (events & pending & ~clr_vec);
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter: reset, single grant, ordering, backpressure,
// mask/overflow, same-edge set/clear, and asynchronous reset during an offer.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in, mask_in;
  logic       out_ready, clear_ovf;
  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] pending_o, ovf_o;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  irq_pending_arbiter #(.N(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending_o (pending_o),
    .ovf_o     (ovf_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: advance one edge, then settle so samples sit away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] r);
    req_in = r;
    tick();
    req_in = 4'b0000;
  endtask

  task automatic expect_state(input string tag, input logic v, input logic [1:0] idx,
                              input logic [3:0] pend, input logic [3:0] ov);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".pend"},  32'(pending_o), 32'(pend));
    check({tag, ".ovf"},   32'(ovf_o),     32'(ov));
  endtask

  initial begin
    logic prev_valid;
    rst_n = 1'b0; req_in = '0; mask_in = 4'b1111; out_ready = 1'b1; clear_ovf = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset / idle
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_state("idle", 1'b0, 2'd0, 4'b0000, 4'b0000);
    end

    // single request: pending after edge k, offer after k+1, cleared on handshake
    pulse(4'b0010);
    expect_state("single_k", 1'b0, 2'd0, 4'b0010, 4'b0000);
    tick();
    expect_state("single_k1", 1'b1, 2'd1, 4'b0010, 4'b0000);
    tick();
    expect_state("single_hs", 1'b0, 2'd1, 4'b0000, 4'b0000);

    // ordering: 3, 1, 0 with a bubble between offers
    exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    pulse(4'b1011);
    check("order.pend", 32'(pending_o), 32'(4'b1011));
    prev_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) begin
        if (exp_q.size() == 0) check("order.extra", 32'(out_idx), 32'hffff_ffff);
        else check("order.idx", 32'(out_idx), 32'(exp_q.pop_front()));
        check("order.bubble", 32'(prev_valid), 32'(0));
      end
      prev_valid = out_valid;
    end
    check("order.left", 32'(exp_q.size()), 32'(0));
    check("order.pend_end", 32'(pending_o), 32'(0));

    // backpressure, no retraction by a higher-priority arrival
    out_ready = 1'b0;
    pulse(4'b0001);
    tick();
    expect_state("bp_offer", 1'b1, 2'd0, 4'b0001, 4'b0000);
    pulse(4'b1000);
    expect_state("bp_hold0", 1'b1, 2'd0, 4'b1001, 4'b0000);
    tick();
    tick();
    expect_state("bp_hold1", 1'b1, 2'd0, 4'b1001, 4'b0000);
    out_ready = 1'b1;
    tick();
    expect_state("bp_hs", 1'b0, 2'd0, 4'b1000, 4'b0000);
    tick();
    expect_state("bp_next", 1'b1, 2'd3, 4'b1000, 4'b0000);
    tick();
    expect_state("bp_done", 1'b0, 2'd3, 4'b0000, 4'b0000);

    // mask and overflow
    mask_in = 4'b1011;
    pulse(4'b0100);
    tick();
    pulse(4'b0100);
    tick();
    expect_state("mask_hold", 1'b0, 2'd3, 4'b0100, 4'b0100);
    mask_in = 4'b1111;
    tick();
    expect_state("mask_offer", 1'b1, 2'd2, 4'b0100, 4'b0100);
    tick();
    expect_state("mask_hs", 1'b0, 2'd2, 4'b0000, 4'b0100);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_clear", 32'(ovf_o), 32'(0));

    // same-edge set and clear: set wins, no overflow
    pulse(4'b0100);
    tick();
    expect_state("same_offer", 1'b1, 2'd2, 4'b0100, 4'b0000);
    pulse(4'b0100);
    expect_state("same_edge", 1'b0, 2'd2, 4'b0100, 4'b0000);
    tick();
    expect_state("same_reoffer", 1'b1, 2'd2, 4'b0100, 4'b0000);
    tick();
    expect_state("same_done", 1'b0, 2'd2, 4'b0000, 4'b0000);

    // async reset mid-offer
    out_ready = 1'b0;
    pulse(4'b1001);
    tick();
    expect_state("rst_pre", 1'b1, 2'd3, 4'b1001, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("rst_async", 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    expect_state("rst_after", 1'b0, 2'd0, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
